// File: rtl/apb_pkg.sv
// Shared APB master types: adapter FSM state encoding and the response status record.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   // rdata is kept beside this record because its width is a module parameter.
   typedef struct packed {
      logic err;
      logic timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_master_adapter.sv
// Valid/ready request to APB master bridge: one transfer at a time, 3-cycle back-to-back
// throughput, optional ACCESS-phase timeout that completes the transfer with an error.
module apb_master_adapter
   import apb_pkg::*;
#(
   parameter int D_WIDTH        = 32,
   parameter int A_WIDTH        = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [A_WIDTH-1:0]   req_addr,
   input  logic [D_WIDTH-1:0]   req_wdata,
   input  logic [D_WIDTH/8-1:0] req_strb,
   output logic                 rsp_valid,
   output logic [D_WIDTH-1:0]   rsp_rdata,
   output logic                 rsp_err,
   output logic                 rsp_timeout,
   output logic [A_WIDTH-1:0]   paddr,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [D_WIDTH-1:0]   pwdata,
   output logic [D_WIDTH/8-1:0] pstrb,
   input  logic [D_WIDTH-1:0]   prdata,
   input  logic                 pready,
   input  logic                 pslverr
);

   localparam int STRB_W = D_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   apb_state_e           state_q, state_d;
   logic [A_WIDTH-1:0]   addr_q, addr_d;
   logic                 write_q, write_d;
   logic [D_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]    strb_q, strb_d;
   logic [D_WIDTH-1:0]   rdata_q, rdata_d;
   apb_rsp_t             rsp_q, rsp_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 accept;
   logic                 timeout_hit;

   // The cycle that would bring the counter to TIMEOUT_CYCLES is the last ACCESS cycle.
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   assign req_ready = presetn && ((state_q == ST_IDLE) || (state_q == ST_RESP));
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      rdata_d = rdata_q;
      rsp_d   = rsp_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               state_d = ST_SETUP;
               addr_d  = req_addr;
               write_d = req_write;
               wdata_d = req_write ? req_wdata : '0;
               strb_d  = req_write ? req_strb : '0;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (pready) begin
               state_d = ST_RESP;
               rdata_d = write_q ? '0 : prdata;
               rsp_d   = '{err: pslverr, timeout: 1'b0};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (timeout_hit) begin
                  state_d = ST_RESP;
                  rdata_d = '0;
                  rsp_d   = '{err: 1'b1, timeout: 1'b1};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
         rsp_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
         rsp_q   <= rsp_d;
         cnt_q   <= cnt_d;
      end
   end

   assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign penable     = (state_q == ST_ACCESS);
   assign paddr       = addr_q;
   assign pwrite      = write_q;
   assign pwdata      = wdata_q;
   assign pstrb       = strb_q;
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_adapter.sv
// Directed bench for apb_master_adapter with a small APB slave model (wait states, error, hang).
module tb_apb_master_adapter;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        req_valid, req_ready, req_write;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [11:0] paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata, prdata;
   logic [3:0]  pstrb;
   logic        pready, pslverr;

   // slave model controls
   int          slv_wait = 0;
   logic        slv_hang = 1'b0;
   logic        slv_err  = 1'b0;
   logic [31:0] slv_rdata = 32'h0;
   int          acc_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   apb_master_adapter #(
      .D_WIDTH(32), .A_WIDTH(12), .TIMEOUT_CYCLES(4)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr)
   );

   always @(posedge pclk or negedge presetn) begin
      if (!presetn)                       acc_cnt <= 0;
      else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                                acc_cnt <= 0;
   end
   assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_wait);
   assign prdata  = slv_rdata;
   assign pslverr = slv_err;

   // Drives one request from IDLE/RESP and stops in the RESP cycle (or after the bound).
   task automatic do_req(input logic wr, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int acc, output bit got, output bit rd_bad);
      acc = 0; got = 0; rd_bad = 0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
      @(posedge pclk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid) begin
            got = 1;
            break;
         end
         if (psel && penable) acc++;
         if (!wr && psel && (pstrb !== 4'h0 || pwdata !== 32'h0)) rd_bad = 1;
         @(posedge pclk); #1;
      end
   endtask

   task automatic test_reset();
      presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_strb = '0;
      repeat (3) @(posedge pclk);
      #1;
      n_checks++; if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, req_ready} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, req_ready}); end
      n_checks++; if ({paddr, pwdata, pstrb, rsp_rdata} !== 80'h0) begin n_fail++; $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%h rdata=%h exp=0", paddr, pwdata, pstrb, rsp_rdata); end
      presetn = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
      @(posedge pclk); #1;
      $display("reset: checks done");
   endtask

   task automatic test_write();
      slv_wait = 0; slv_hang = 0; slv_err = 0; slv_rdata = 32'h55AA_55AA;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h0AB; req_wdata = 32'hDEAD_BEEF; req_strb = 4'hF;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_idle_ready got=%b exp=1", req_ready); end
      @(posedge pclk); #1;
      req_valid = 1'b0;
      n_checks++; if ({psel, penable, pwrite, req_ready, rsp_valid} !== 5'b10100) begin n_fail++; $display("FAIL wr_setup_ctrl got=%b exp=10100", {psel, penable, pwrite, req_ready, rsp_valid}); end
      n_checks++; if (paddr !== 12'h0AB || pwdata !== 32'hDEAD_BEEF || pstrb !== 4'hF) begin n_fail++; $display("FAIL wr_setup_data paddr=%h pwdata=%h pstrb=%h exp 0ab/deadbeef/f", paddr, pwdata, pstrb); end
      @(posedge pclk); #1;
      n_checks++; if ({psel, penable, rsp_valid, req_ready} !== 4'b1100) begin n_fail++; $display("FAIL wr_access_ctrl got=%b exp=1100", {psel, penable, rsp_valid, req_ready}); end
      n_checks++; if (paddr !== 12'h0AB || pwdata !== 32'hDEAD_BEEF || pstrb !== 4'hF) begin n_fail++; $display("FAIL wr_access_data paddr=%h pwdata=%h pstrb=%h exp 0ab/deadbeef/f", paddr, pwdata, pstrb); end
      @(posedge pclk); #1;
      n_checks++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable, req_ready} !== 6'b100001) begin n_fail++; $display("FAIL wr_resp got=%b exp=100001", {rsp_valid, rsp_err, rsp_timeout, psel, penable, req_ready}); end
      n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata got=%h exp=00000000", rsp_rdata); end
      @(posedge pclk); #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_resp_pulse got=%b exp=0", rsp_valid); end
      $display("write 0x0ab: rsp_err=%b rdata=%h", rsp_err, rsp_rdata);
   endtask

   task automatic test_read_wait();
      int acc; bit got, bad;
      slv_wait = 2; slv_hang = 0; slv_err = 0; slv_rdata = 32'h1234_5678;
      do_req(1'b0, 12'h004, 32'hFFFF_FFFF, 4'hF, acc, got, bad);
      n_checks++; if (!got) begin n_fail++; $display("FAIL rd_no_rsp got=0 exp=1"); end
      n_checks++; if (acc != 3) begin n_fail++; $display("FAIL rd_access_cycles got=%0d exp=3", acc); end
      n_checks++; if (bad) begin n_fail++; $display("FAIL rd_pstrb_pwdata_nonzero got=1 exp=0"); end
      n_checks++; if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_data got=%h err=%b exp=12345678 err=0", rsp_rdata, rsp_err); end
      slv_rdata = 32'h0BAD_0BAD;
      @(posedge pclk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_hold valid=%b rdata=%h exp 0/12345678", rsp_valid, rsp_rdata); end
      $display("read 0x004: acc=%0d rdata=%h", acc, rsp_rdata);
   endtask

   task automatic test_slverr();
      int acc; bit got, bad;
      slv_wait = 0; slv_hang = 0; slv_err = 1; slv_rdata = 32'hA5A5_A5A5;
      do_req(1'b0, 12'h010, 32'h0, 4'h0, acc, got, bad);
      n_checks++; if (!got || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL slverr got_rsp=%b err=%b to=%b exp 1/1/0", got, rsp_err, rsp_timeout); end
      n_checks++; if (rsp_rdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL slverr_rdata got=%h exp=a5a5a5a5", rsp_rdata); end
      slv_err = 0;
      @(posedge pclk); #1;
      $display("read slverr: err=%b timeout=%b", rsp_err, rsp_timeout);
   endtask

   task automatic test_timeout();
      int acc; bit got, bad;
      slv_wait = 0; slv_hang = 1; slv_err = 0; slv_rdata = 32'hCAFE_F00D;
      do_req(1'b0, 12'h020, 32'h0, 4'h0, acc, got, bad);
      n_checks++; if (!got) begin n_fail++; $display("FAIL to_no_rsp got=0 exp=1"); end
      n_checks++; if (acc != 4) begin n_fail++; $display("FAIL to_access_cycles got=%0d exp=4", acc); end
      n_checks++; if ({psel, rsp_err, rsp_timeout} !== 3'b011 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_resp psel=%b err=%b to=%b rdata=%h exp 0/1/1/0", psel, rsp_err, rsp_timeout, rsp_rdata); end
      slv_hang = 0;
      @(posedge pclk); #1;
      $display("timeout read: acc=%0d err=%b timeout=%b", acc, rsp_err, rsp_timeout);
   endtask

   task automatic test_back_to_back();
      int accepts, nrise, nrsp, rise0, rise1;
      logic [11:0] addr0, addr1;
      bit acc_now, second_in_resp, prev_psel;
      slv_wait = 0; slv_hang = 0; slv_err = 0;
      accepts = 0; nrise = 0; nrsp = 0; rise0 = -1; rise1 = -1;
      addr0 = '0; addr1 = '0; second_in_resp = 0; prev_psel = 0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h100; req_wdata = 32'h1111_1111; req_strb = 4'h3;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (psel && !prev_psel) begin
            if (nrise == 0) begin rise0 = cyc; addr0 = paddr; end
            else if (nrise == 1) begin rise1 = cyc; addr1 = paddr; end
            nrise++;
         end
         prev_psel = psel;
         if (rsp_valid) nrsp++;
         acc_now = req_valid && req_ready;
         if (acc_now) begin
            accepts++;
            if (accepts == 2) second_in_resp = rsp_valid;
         end
         @(posedge pclk); #1;
         if (acc_now && accepts == 1) begin req_addr = 12'h104; req_wdata = 32'h2222_2222; end
         else if (acc_now && accepts == 2) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      n_checks++; if (!second_in_resp || accepts != 2) begin n_fail++; $display("FAIL b2b_accept_in_resp got=%b accepts=%0d exp 1/2", second_in_resp, accepts); end
      n_checks++; if (nrise != 2 || rise1 - rise0 != 3) begin n_fail++; $display("FAIL b2b_psel_gap rises=%0d gap=%0d exp 2/3", nrise, rise1 - rise0); end
      n_checks++; if (addr0 !== 12'h100 || addr1 !== 12'h104 || nrsp != 2) begin n_fail++; $display("FAIL b2b_addr a0=%h a1=%h rsps=%0d exp 100/104/2", addr0, addr1, nrsp); end
      $display("back-to-back: psel rises at %0d and %0d, %0d responses", rise0, rise1, nrsp);
   endtask

   task automatic test_reset_mid_access();
      int acc; bit got, bad;
      slv_wait = 0; slv_hang = 1; slv_err = 0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h040;
      @(posedge pclk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      n_checks++; if (!(psel && penable)) begin n_fail++; $display("FAIL rst_mid_in_access psel=%b penable=%b exp 1/1", psel, penable); end
      presetn = 1'b0;
      #1;
      n_checks++; if ({psel, penable, rsp_valid, req_ready} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_async got=%b exp=0000", {psel, penable, rsp_valid, req_ready}); end
      @(posedge pclk); #1;
      presetn = 1'b1; slv_hang = 0;
      #1;
      n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_release ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
      @(posedge pclk); #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp got=%b exp=0", rsp_valid); end
      do_req(1'b1, 12'h050, 32'h3333_4444, 4'hC, acc, got, bad);
      n_checks++; if (!got || acc != 1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_mid_followup got=%b acc=%0d err=%b to=%b exp 1/1/0/0", got, acc, rsp_err, rsp_timeout); end
      @(posedge pclk); #1;
      $display("reset mid-access: follow-up write got_rsp=%b err=%b", got, rsp_err);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_master_adapter.md
APB_MASTER_ADAPTER -- requirements
Module: apb_master_adapter

Interface
REQ-001 D_WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 A_WIDTH, default 12, address width in bits.
REQ-003 TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-004 pclk  in  1  clock; all logic on rising edge.
REQ-005 presetn  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  A_WIDTH  request address.
REQ-010 req_wdata  in  D_WIDTH  write data.
REQ-011 req_strb  in  D_WIDTH/8  write byte enables.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  D_WIDTH  read data; valid with rsp_valid.
REQ-014 rsp_err  out  1  slave error or timeout; valid with rsp_valid.
REQ-015 rsp_timeout  out  1  completion caused by timeout; valid with rsp_valid.
REQ-016 paddr  out  A_WIDTH  APB address.
REQ-017 psel  out  1  APB select.
REQ-018 penable  out  1  APB enable.
REQ-019 pwrite  out  1  APB direction.
REQ-020 pwdata  out  D_WIDTH  APB write data.
REQ-021 pstrb  out  D_WIDTH/8  APB write strobes.
REQ-022 prdata  in  D_WIDTH  APB read data.
REQ-023 pready  in  1  APB ready.
REQ-024 pslverr  in  1  APB slave error.

Function
REQ-025 FSM SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-026 req_ready SHALL be 1 in IDLE and RESP and 0 in SETUP and ACCESS.
REQ-027 On acceptance, req_write, req_addr, req_wdata and req_strb SHALL be registered, and the FSM SHALL move to SETUP on the next cycle.
REQ-028 In SETUP: psel=1, penable=0; the FSM SHALL always move to ACCESS on the next cycle, and pready in SETUP SHALL be ignored.
REQ-029 In ACCESS: psel=1, penable=1; paddr, pwrite, pwdata and pstrb SHALL hold their registered values from SETUP until exit.
REQ-030 For reads, pwdata SHALL be 0 and pstrb SHALL be 0.
REQ-031 ACCESS with pready=1 SHALL capture prdata (0 for writes) into rsp_rdata and pslverr into rsp_err, with rsp_timeout=0, and go to RESP.
REQ-032 pslverr SHALL be sampled only in ACCESS when pready=1.
REQ-033 In RESP, rsp_valid=1 for exactly one cycle, and psel=0, penable=0.
REQ-034 From RESP, the FSM SHALL go to SETUP if a request is accepted that cycle, else to IDLE.
REQ-035 Back-to-back transfers SHALL therefore take 3 cycles each.
REQ-036 The wait counter SHALL clear on SETUP entry and increment each ACCESS cycle without pready; its width is $clog2(TIMEOUT_CYCLES+1).
REQ-037 When the counter reaches TIMEOUT_CYCLES (nonzero parameter), the FSM SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready arriving in the same cycle SHALL take priority as a normal completion.
REQ-038 rsp_rdata, rsp_err and rsp_timeout SHALL hold their last values outside rsp_valid.

Reset
REQ-039 During reset: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-040 Reset during SETUP or ACCESS SHALL drop psel and penable immediately, SHALL generate no response, and req_ready SHALL be 1 in the first cycle after release.

Structure
REQ-041 The FSM state enum and the response-record typedef SHALL live in the shared apb_pkg package.
REQ-042 There are no sub-modules; the block is a single module.

Verification
REQ-043 Write 0x0AB / 0xDEADBEEF / strb 0xF with pready tied high -> SETUP then ACCESS, with rsp_valid 3 cycles after acceptance, rsp_err=0, and pstrb=0xF during the transfer.
REQ-044 Read 0x004, with pready after 2 wait cycles and prdata=0x12345678 -> rsp_rdata=0x12345678, and pstrb=0 throughout.
REQ-045 Read with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-046 TIMEOUT_CYCLES=4, pready held low -> psel drops after 4 ACCESS cycles, and rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-047 Two requests held back-to-back -> the second is accepted in RESP, and successive psel rising edges are 3 cycles apart.
REQ-048 presetn asserted mid-ACCESS -> psel=0 asynchronously, no rsp_valid, and a following request completes normally.
